// File: rtl/dkong_dma_pkg.sv
// Shared types and helpers for the multi-channel sprite DMA: FSM state encoding,
// transfer mode constants and per-channel field extraction from packed buses.
package dkong_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_READ,
        ST_WRITE,
        ST_RELEASE
    } dma_state_e;

    localparam logic MODE_BURST = 1'b0;
    localparam logic MODE_STEAL = 1'b1;

    localparam int FIELD_BUS_W = 128;

    // Field idx of width w (w < 32) from a bus of back-to-back per-channel fields.
    function automatic logic [31:0] ch_field(input logic [FIELD_BUS_W-1:0] bus,
                                             input int unsigned idx,
                                             input int unsigned w);
        return 32'(bus >> (idx * w)) & ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/dkong_dma_arb.sv
// Trigger rising-edge capture into per-channel pending bits and a fixed-priority
// (lowest index wins) grant. Runs every clock, independent of the step enable.
module dkong_dma_arb #(
    parameter int NUM_CH = 2,
    parameter int IW     = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_CH-1:0] trig_i,
    input  logic              clr_i,
    input  logic [IW-1:0]     clr_idx_i,
    output logic [NUM_CH-1:0] pend_o,
    output logic              grant_vld_o,
    output logic [IW-1:0]     grant_idx_o
);

    logic [NUM_CH-1:0] trig_q;
    logic [NUM_CH-1:0] pend_q;
    logic [NUM_CH-1:0] pend_d;
    logic [NUM_CH-1:0] clr_mask;

    // A new edge wins over the clear so a re-trigger on the start clock is kept.
    always_comb begin
        clr_mask = '0;
        if (clr_i) begin
            clr_mask[clr_idx_i] = 1'b1;
        end
        pend_d = (pend_q & ~clr_mask) | (trig_i & ~trig_q);
    end

    always_comb begin
        grant_vld_o = 1'b0;
        grant_idx_o = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                grant_vld_o = 1'b1;
                grant_idx_o = IW'(i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            trig_q <= '0;
            pend_q <= '0;
        end else begin
            trig_q <= trig_i;
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/dkong_dma_mc.sv
// Multi-channel block copy from a synchronous source RAM port to a destination
// RAM port, gated by the Z80 BUSRQ/BUSAK handshake; burst or cycle-steal.
module dkong_dma_mc #(
    parameter int NUM_CH = 2,
    parameter int AW     = 10,
    parameter int DW     = 8,
    parameter int LEN_W  = 10
) (
    input  logic                    I_CLK,
    input  logic                    I_RST,
    input  logic                    I_CLK_EN,
    input  logic [NUM_CH-1:0]       I_TRIG,
    input  logic [NUM_CH*AW-1:0]    I_CH_SRC,
    input  logic [NUM_CH*AW-1:0]    I_CH_DST,
    input  logic [NUM_CH*LEN_W-1:0] I_CH_LEN,
    input  logic                    I_MODE,
    input  logic                    I_HLDA,
    output logic                    O_HRQ,
    output logic [AW-1:0]           O_DMA_AS,
    output logic                    O_DMA_CES,
    input  logic [DW-1:0]           I_DMA_DS,
    output logic [AW-1:0]           O_DMA_AD,
    output logic [DW-1:0]           O_DMA_DD,
    output logic                    O_DMA_CED,
    output logic [NUM_CH-1:0]       O_BUSY,
    output logic [NUM_CH-1:0]       O_DONE
);
    import dkong_dma_pkg::*;

    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    dma_state_e        state_q;
    logic [IW-1:0]     act_q;
    logic [AW-1:0]     src_q;
    logic [AW-1:0]     dst_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [DW-1:0]     data_q;
    logic              cap_q;
    logic              hrq_q;
    logic [AW-1:0]     as_q;
    logic              ces_q;
    logic [AW-1:0]     ad_q;
    logic [DW-1:0]     dd_q;
    logic              ced_q;
    logic [NUM_CH-1:0] done_q;

    logic [NUM_CH-1:0] pend;
    logic              grant_vld;
    logic [IW-1:0]     grant_idx;
    logic              start_clr;
    logic [AW-1:0]     sel_src;
    logic [AW-1:0]     sel_dst;
    logic [LEN_W-1:0]  sel_len;

    assign start_clr = I_CLK_EN && (state_q == ST_IDLE) && grant_vld;

    dkong_dma_arb #(
        .NUM_CH (NUM_CH),
        .IW     (IW)
    ) u_arb (
        .clk_i       (I_CLK),
        .rst_i       (I_RST),
        .trig_i      (I_TRIG),
        .clr_i       (start_clr),
        .clr_idx_i   (grant_idx),
        .pend_o      (pend),
        .grant_vld_o (grant_vld),
        .grant_idx_o (grant_idx)
    );

    assign sel_src = AW'(ch_field(FIELD_BUS_W'(I_CH_SRC), 32'(grant_idx), AW));
    assign sel_dst = AW'(ch_field(FIELD_BUS_W'(I_CH_DST), 32'(grant_idx), AW));
    assign sel_len = LEN_W'(ch_field(FIELD_BUS_W'(I_CH_LEN), 32'(grant_idx), LEN_W));

    // Strobes are single-clock; source data lands two clocks after the read
    // strobe is registered, well inside one enable period.
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state_q <= ST_IDLE;
            act_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            cap_q   <= 1'b0;
            hrq_q   <= 1'b0;
            as_q    <= '0;
            ces_q   <= 1'b0;
            ad_q    <= '0;
            dd_q    <= '0;
            ced_q   <= 1'b0;
            done_q  <= '0;
        end else begin
            ces_q  <= 1'b0;
            ced_q  <= 1'b0;
            done_q <= '0;
            cap_q  <= ces_q;
            if (cap_q) begin
                data_q <= I_DMA_DS;
            end
            if (I_CLK_EN) begin
                case (state_q)
                    ST_IDLE: begin
                        if (grant_vld) begin
                            act_q <= grant_idx;
                            src_q <= sel_src;
                            dst_q <= sel_dst;
                            cnt_q <= sel_len;
                            if (sel_len == '0) begin
                                done_q[grant_idx] <= 1'b1;
                            end else begin
                                state_q <= ST_REQ;
                                hrq_q   <= 1'b1;
                            end
                        end
                    end
                    ST_REQ: begin
                        if (I_HLDA) begin
                            state_q <= ST_READ;
                            as_q    <= src_q;
                            ces_q   <= 1'b1;
                        end
                    end
                    ST_READ: begin
                        if (I_HLDA) begin
                            state_q <= ST_WRITE;
                            ad_q    <= dst_q;
                            dd_q    <= data_q;
                            ced_q   <= 1'b1;
                            src_q   <= src_q + 1'b1;
                            dst_q   <= dst_q + 1'b1;
                            cnt_q   <= cnt_q - 1'b1;
                        end
                    end
                    ST_WRITE: begin
                        if (cnt_q == '0) begin
                            state_q        <= ST_IDLE;
                            hrq_q          <= 1'b0;
                            done_q[act_q]  <= 1'b1;
                        end else if (I_MODE == MODE_STEAL) begin
                            state_q <= ST_RELEASE;
                            hrq_q   <= 1'b0;
                        end else if (I_HLDA) begin
                            state_q <= ST_READ;
                            as_q    <= src_q;
                            ces_q   <= 1'b1;
                        end
                    end
                    ST_RELEASE: begin
                        state_q <= ST_REQ;
                        hrq_q   <= 1'b1;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        hrq_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        O_BUSY = pend;
        if (state_q != ST_IDLE) begin
            O_BUSY[act_q] = 1'b1;
        end
    end

    assign O_HRQ     = hrq_q;
    assign O_DMA_AS  = as_q;
    assign O_DMA_CES = ces_q;
    assign O_DMA_AD  = ad_q;
    assign O_DMA_DD  = dd_q;
    assign O_DMA_CED = ced_q;
    assign O_DONE    = done_q;

endmodule

// File: tb/tb_dkong_dma_mc.sv
// Bench for dkong_dma_mc: source RAM and BUSAK models, scoreboard of expected
// reads/writes/done pulses, a vector table plus multi-cycle corner sequences.
module tb_dkong_dma_mc;

    localparam int NUM_CH = 2;
    localparam int AW     = 10;
    localparam int DW     = 8;
    localparam int LEN_W  = 10;
    localparam int W      = AW + DW;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    clk_en;
    logic [NUM_CH-1:0]       trig;
    logic [NUM_CH*AW-1:0]    src_bus;
    logic [NUM_CH*AW-1:0]    dst_bus;
    logic [NUM_CH*LEN_W-1:0] len_bus;
    logic                    mode;
    logic                    hlda;
    logic                    hrq;
    logic [AW-1:0]           dma_as;
    logic                    ces;
    logic [DW-1:0]           ds;
    logic [AW-1:0]           dma_ad;
    logic [DW-1:0]           dma_dd;
    logic                    ced;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH-1:0]       done;

    dkong_dma_mc #(
        .NUM_CH (NUM_CH),
        .AW     (AW),
        .DW     (DW),
        .LEN_W  (LEN_W)
    ) dut (
        .I_CLK     (clk),
        .I_RST     (rst),
        .I_CLK_EN  (clk_en),
        .I_TRIG    (trig),
        .I_CH_SRC  (src_bus),
        .I_CH_DST  (dst_bus),
        .I_CH_LEN  (len_bus),
        .I_MODE    (mode),
        .I_HLDA    (hlda),
        .O_HRQ     (hrq),
        .O_DMA_AS  (dma_as),
        .O_DMA_CES (ces),
        .I_DMA_DS  (ds),
        .O_DMA_AD  (dma_ad),
        .O_DMA_DD  (dma_dd),
        .O_DMA_CED (ced),
        .O_BUSY    (busy),
        .O_DONE    (done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] src_mem [0:(1<<AW)-1];
    logic [W-1:0]  exp_q[$];
    logic [AW-1:0] exp_rd_q[$];
    int            exp_done_q[$];

    int   checks = 0;
    int   errors = 0;
    int   wr_cnt = 0;
    int   rd_cnt = 0;
    int   n_rise = 0;
    int   n_fall = 0;
    int   gaps = 0;
    int   bad_gaps = 0;
    int   low_run = 0;
    bit   had_fall = 1'b0;
    logic hrq_prev = 1'b0;
    bit   hlda_block = 1'b0;
    logic hlda_at_edge = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Enable every 8th clock, BUSAK following BUSRQ one enable late, and a
    // source RAM that presents data for one clock, one clock after the strobe.
    initial begin
        int            en_cnt;
        logic          ces_d1;
        logic [AW-1:0] as_d1;
        bit            last_en;
        en_cnt  = 0;
        ces_d1  = 1'b0;
        as_d1   = '0;
        last_en = 1'b0;
        clk_en  = 1'b0;
        hlda    = 1'b0;
        ds      = '0;
        forever begin
            @(posedge clk);
            #2;
            if (ces_d1) ds = src_mem[as_d1];
            else        ds = DW'($urandom_range(0, 255));
            ces_d1 = ces;
            as_d1  = dma_as;
            if (last_en) hlda = hrq & ~hlda_block;
            en_cnt  = (en_cnt + 1) % 8;
            clk_en  = (en_cnt == 0);
            last_en = clk_en;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            hlda_at_edge = hlda;
            @(negedge clk);
            if (ces) begin
                rd_cnt++;
                check("ces_hlda", 32'(hlda_at_edge), 32'd1);
                if (exp_rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected actual=0x%0h required=none", dma_as);
                end else begin
                    check("rd_addr", 32'(dma_as), 32'(exp_rd_q.pop_front()));
                end
            end
            if (ced) begin
                wr_cnt++;
                check("ced_hlda", 32'(hlda_at_edge), 32'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected actual=0x%0h required=none", {dma_ad, dma_dd});
                end else begin
                    check("wr_addr_data", 32'({dma_ad, dma_dd}), 32'(exp_q.pop_front()));
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (done[i]) begin
                    if (exp_done_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL done_unexpected actual=%0d required=none", i);
                    end else begin
                        check("done_ch", 32'(i), 32'(exp_done_q.pop_front()));
                    end
                end
            end
            if (hrq && !hrq_prev) begin
                n_rise++;
                if (had_fall) begin
                    gaps++;
                    if (low_run != 8) bad_gaps++;
                end
            end
            if (!hrq && hrq_prev) begin
                n_fall++;
                had_fall = 1'b1;
                low_run  = 0;
            end
            if (!hrq) low_run++;
            hrq_prev = hrq;
        end
    end

    task automatic program_ch(input int ch, input logic [AW-1:0] s, input logic [AW-1:0] d,
                              input logic [LEN_W-1:0] l);
        src_bus[ch*AW +: AW]       = s;
        dst_bus[ch*AW +: AW]       = d;
        len_bus[ch*LEN_W +: LEN_W] = l;
    endtask

    task automatic push_expect(input int ch, input logic [AW-1:0] s, input logic [AW-1:0] d,
                               input int l);
        for (int i = 0; i < l; i++) begin
            logic [AW-1:0] sa;
            logic [AW-1:0] da;
            sa = AW'(32'(s) + i);
            da = AW'(32'(d) + i);
            exp_rd_q.push_back(sa);
            exp_q.push_back({da, src_mem[sa]});
        end
        exp_done_q.push_back(ch);
    endtask

    task automatic pulse_trig(input logic [NUM_CH-1:0] m);
        @(posedge clk);
        #2;
        trig = trig | m;
        @(posedge clk);
        #2;
        trig = trig & ~m;
    endtask

    task automatic clear_hrq_stats();
        n_rise   = 0;
        n_fall   = 0;
        gaps     = 0;
        bad_gaps = 0;
        had_fall = 1'b0;
    endtask

    task automatic wait_writes(input string name, input int target);
        int n;
        n = 0;
        while (wr_cnt < target && n < 5000) begin
            @(posedge clk);
            #2;
            n++;
        end
        check({name, "_reached"}, 32'(wr_cnt >= target), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (busy != '0 && n < 10000);
        repeat (4) @(posedge clk);
        #2;
        check({name, "_idle"}, 32'(n < 10000), 32'd1);
        check({name, "_wr_left"}, 32'(exp_q.size()), 32'd0);
        check({name, "_rd_left"}, 32'(exp_rd_q.size()), 32'd0);
        check({name, "_done_left"}, 32'(exp_done_q.size()), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_hrq"}, 32'(hrq), 32'd0);
        check({name, "_ces"}, 32'(ces), 32'd0);
        check({name, "_ced"}, 32'(ced), 32'd0);
        check({name, "_as"}, 32'(dma_as), 32'd0);
        check({name, "_ad"}, 32'(dma_ad), 32'd0);
        check({name, "_dd"}, 32'(dma_dd), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
    endtask

    typedef struct {
        int               ch;
        logic [AW-1:0]    src;
        logic [AW-1:0]    dst;
        logic [LEN_W-1:0] len;
        logic             mode;
        logic             exp_hrq;
        int               exp_gaps;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int wr_base;
        for (int i = 0; i < (1 << AW); i++) src_mem[i] = DW'($urandom_range(0, 255));

        vecs[0] = '{0, 10'h100, 10'h000, 10'h180, 1'b0, 1'b1, 0};
        vecs[1] = '{0, 10'h3FE, 10'h200, 10'd4,   1'b0, 1'b1, 0};
        vecs[2] = '{1, 10'h050, 10'h300, 10'd3,   1'b1, 1'b1, 2};
        vecs[3] = '{1, 10'h000, 10'h000, 10'd0,   1'b0, 1'b0, 0};
        vecs[4] = '{1, 10'h3F0, 10'h3FD, 10'd6,   1'b0, 1'b1, 0};
        vecs[5] = '{0, 10'h123, 10'h080, 10'd5,   1'b1, 1'b1, 4};

        rst     = 1'b1;
        trig    = '0;
        src_bus = '0;
        dst_bus = '0;
        len_bus = '0;
        mode    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #2;

        for (int v = 0; v < 6; v++) begin
            mode = vecs[v].mode;
            program_ch(vecs[v].ch, vecs[v].src, vecs[v].dst, vecs[v].len);
            push_expect(vecs[v].ch, vecs[v].src, vecs[v].dst, int'(vecs[v].len));
            clear_hrq_stats();
            pulse_trig(NUM_CH'(1) << vecs[v].ch);
            wait_idle($sformatf("vec%0d", v));
            check($sformatf("vec%0d_hrq_seen", v), 32'(n_rise > 0), 32'(vecs[v].exp_hrq));
            check($sformatf("vec%0d_hrq_gaps", v), 32'(gaps), 32'(vecs[v].exp_gaps));
            check($sformatf("vec%0d_gap_len", v), 32'(bad_gaps), 32'd0);
            check($sformatf("vec%0d_hrq_falls", v), 32'(n_fall),
                  32'(vecs[v].exp_gaps) + 32'(vecs[v].exp_hrq));
        end

        mode = 1'b0;
        // Same-clock triggers: ch0 first, ch1 queued behind it.
        program_ch(0, 10'h010, 10'h100, 10'd4);
        program_ch(1, 10'h020, 10'h110, 10'd4);
        push_expect(0, 10'h010, 10'h100, 4);
        push_expect(1, 10'h020, 10'h110, 4);
        pulse_trig(2'b11);
        wait_idle("prio");

        // Higher priority arriving mid-transfer waits; mid-run input changes ignored.
        program_ch(1, 10'h040, 10'h140, 10'd6);
        push_expect(1, 10'h040, 10'h140, 6);
        wr_base = wr_cnt;
        pulse_trig(2'b10);
        wait_writes("nopreempt", wr_base + 2);
        program_ch(1, 10'h2AA, 10'h2BB, 10'd9);
        program_ch(0, 10'h060, 10'h160, 10'd3);
        push_expect(0, 10'h060, 10'h160, 3);
        pulse_trig(2'b01);
        wait_idle("nopreempt");

        // Re-trigger of the active channel runs it again after completion.
        program_ch(0, 10'h080, 10'h180, 10'd4);
        push_expect(0, 10'h080, 10'h180, 4);
        wr_base = wr_cnt;
        pulse_trig(2'b01);
        wait_writes("retrig", wr_base + 2);
        push_expect(0, 10'h080, 10'h180, 4);
        pulse_trig(2'b01);
        wait_idle("retrig");

        // BUSAK withdrawn for 10 enables after the fifth byte.
        program_ch(0, 10'h0A0, 10'h1A0, 10'd8);
        push_expect(0, 10'h0A0, 10'h1A0, 8);
        clear_hrq_stats();
        wr_base = wr_cnt;
        pulse_trig(2'b01);
        wait_writes("hlda_drop", wr_base + 5);
        hlda_block = 1'b1;
        repeat (80) @(posedge clk);
        #2;
        check("hlda_drop_stall_writes", 32'(wr_cnt - wr_base), 32'd5);
        check("hlda_drop_hrq", 32'(hrq), 32'd1);
        hlda_block = 1'b0;
        wait_idle("hlda_drop");
        check("hlda_drop_hrq_falls", 32'(n_fall), 32'd1);

        // Reset after three bytes abandons the copy.
        program_ch(0, 10'h0C0, 10'h1C0, 10'd10);
        push_expect(0, 10'h0C0, 10'h1C0, 10);
        wr_base = wr_cnt;
        pulse_trig(2'b01);
        wait_writes("rst_mid", wr_base + 3);
        rst = 1'b1;
        exp_q.delete();
        exp_rd_q.delete();
        exp_done_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_all_zero("rst_mid");
        wr_base = wr_cnt;
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (100) @(posedge clk);
        #2;
        check("rst_mid_no_writes", 32'(wr_cnt - wr_base), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        program_ch(0, 10'h0C0, 10'h1C0, 10'd4);
        push_expect(0, 10'h0C0, 10'h1C0, 4);
        pulse_trig(2'b01);
        wait_idle("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
